// File: rtl/exc_pkg.sv
// Shared constants and helpers for the exception-code encoder.
package exc_pkg;

    typedef logic [3:0] code_t;
    typedef logic [3:0] mode_t;

    localparam code_t CODE_NONE      = 4'd0;
    localparam code_t CODE_RESTART   = 4'd1;
    localparam code_t CODE_ERROR     = 4'd2;
    localparam code_t CODE_RESUME    = 4'd3;
    localparam code_t CODE_PAUSE     = 4'd4;
    localparam code_t CODE_UART_REQ  = 4'd5;
    localparam code_t CODE_UART_DONE = 4'd6;

    localparam mode_t MODE_ERROR = 4'd2;
    localparam mode_t MODE_PAUSE = 4'd4;
    localparam mode_t MODE_RUN   = 4'd5;
    localparam mode_t MODE_UART  = 4'd6;

    localparam int ACK_TIMEOUT_DEF = 15;

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_WAIT_ACK = 1'b1
    } state_e;

    // Mode the clock controller must reach to acknowledge a code.
    function automatic mode_t code_target(input code_t code);
        mode_t t;
        case (code)
            CODE_RESTART:   t = MODE_RUN;
            CODE_ERROR:     t = MODE_ERROR;
            CODE_RESUME:    t = MODE_RUN;
            CODE_PAUSE:     t = MODE_PAUSE;
            CODE_UART_REQ:  t = MODE_UART;
            CODE_UART_DONE: t = MODE_RUN;
            default:        t = 4'd0;
        endcase
        return t;
    endfunction

    // Whether a code makes sense in the current mode; otherwise it is dropped.
    function automatic logic code_applicable(input code_t code, input mode_t mode);
        logic a;
        case (code)
            CODE_RESTART:   a = (mode != MODE_UART);
            CODE_ERROR:     a = (mode != MODE_UART);
            CODE_RESUME:    a = (mode == MODE_PAUSE);
            CODE_PAUSE:     a = (mode != MODE_ERROR) && (mode != MODE_UART);
            CODE_UART_REQ:  a = 1'b1;
            CODE_UART_DONE: a = (mode == MODE_UART);
            default:        a = 1'b0;
        endcase
        return a;
    endfunction

    // Pending-vector bit owned by a code (bit k-1 holds code k).
    function automatic logic [5:0] code_mask(input code_t code);
        logic [5:0] m;
        case (code)
            CODE_RESTART:   m = 6'b000001;
            CODE_ERROR:     m = 6'b000010;
            CODE_RESUME:    m = 6'b000100;
            CODE_PAUSE:     m = 6'b001000;
            CODE_UART_REQ:  m = 6'b010000;
            CODE_UART_DONE: m = 6'b100000;
            default:        m = 6'b000000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/exc_encoder_if.sv
// Event inputs and code/status outputs of the exception encoder.
interface exc_encoder_if;
    import exc_pkg::*;

    logic        ill_instr_i;
    logic        misalign_i;
    logic        restart_req_i;
    logic        pause_req_i;
    logic        resume_req_i;
    logic        uart_req_i;
    logic        uart_done_i;
    logic [31:0] pc_i;
    mode_t       mode_i;

    code_t       exc_code_o;
    logic        busy_o;
    logic [31:0] epc_o;
    logic [1:0]  cause_o;
    logic        timeout_o;
    logic [7:0]  drop_cnt_o;

    modport slave (
        input  ill_instr_i, misalign_i, restart_req_i, pause_req_i,
               resume_req_i, uart_req_i, uart_done_i, pc_i, mode_i,
        output exc_code_o, busy_o, epc_o, cause_o, timeout_o, drop_cnt_o
    );

    modport master (
        output ill_instr_i, misalign_i, restart_req_i, pause_req_i,
               resume_req_i, uart_req_i, uart_done_i, pc_i, mode_i,
        input  exc_code_o, busy_o, epc_o, cause_o, timeout_o, drop_cnt_o
    );

endinterface

// File: rtl/exc_prio_sel.sv
// Picks the highest-priority pending event and classifies it against the mode.
module exc_prio_sel
    import exc_pkg::*;
(
    input  logic [5:0] pend_i,
    input  mode_t      mode_i,
    output logic       valid_o,
    output code_t      code_o,
    output mode_t      target_o,
    output logic       appl_o,
    output logic [5:0] mask_o
);

    code_t code_s;

    // Fixed priority: error, restart, uart request, uart done, pause, resume.
    always_comb begin
        code_s = CODE_NONE;
        if (pend_i[1]) begin
            code_s = CODE_ERROR;
        end else if (pend_i[0]) begin
            code_s = CODE_RESTART;
        end else if (pend_i[4]) begin
            code_s = CODE_UART_REQ;
        end else if (pend_i[5]) begin
            code_s = CODE_UART_DONE;
        end else if (pend_i[3]) begin
            code_s = CODE_PAUSE;
        end else if (pend_i[2]) begin
            code_s = CODE_RESUME;
        end else begin
            code_s = CODE_NONE;
        end
    end

    assign valid_o  = (code_s != CODE_NONE);
    assign code_o   = code_s;
    assign target_o = code_target(code_s);
    assign appl_o   = code_applicable(code_s, mode_i);
    assign mask_o   = code_mask(code_s);

endmodule

// File: rtl/exc_encoder.sv
// Turns exception/control pulses into one code at a time for the clock
// controller and waits for the matching mode before issuing the next.
module exc_encoder
    import exc_pkg::*;
#(
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
    input  logic          clk_i,
    input  logic          rst_i,
    exc_encoder_if.slave  bus
);

    // Timer counts completed WAIT_ACK cycles minus one; expiry on the last value.
    localparam int TW = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(ACK_TIMEOUT - 1);
    localparam logic [TW-1:0] TIMER_ONE  = TW'(32'd1);
    localparam logic [TW-1:0] TIMER_ZERO = TW'(32'd0);

    state_e        state_q, state_d;
    logic [5:0]    pend_q, pend_d;
    code_t         code_q, code_d;
    mode_t         target_q, target_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          busy_q, busy_d;
    logic          timeout_q, timeout_d;
    logic [7:0]    drop_q, drop_d;
    logic          capt_q, capt_d;
    logic [31:0]   epc_q, epc_d;
    logic [1:0]    cause_q, cause_d;

    logic          sel_valid_s;
    code_t         sel_code_s;
    mode_t         sel_target_s;
    logic          sel_appl_s;
    logic [5:0]    sel_mask_s;
    logic [5:0]    pend_clr_s;
    logic [5:0]    evt_s;
    logic          err_s;
    logic          capt_clr_s;

    assign err_s = bus.ill_instr_i | bus.misalign_i;
    assign evt_s = {bus.uart_done_i, bus.uart_req_i, bus.pause_req_i,
                    bus.resume_req_i, err_s, bus.restart_req_i};

    exc_prio_sel u_prio_sel (
        .pend_i   (pend_q),
        .mode_i   (bus.mode_i),
        .valid_o  (sel_valid_s),
        .code_o   (sel_code_s),
        .target_o (sel_target_s),
        .appl_o   (sel_appl_s),
        .mask_o   (sel_mask_s)
    );

    // Next-state: service one pending event in IDLE, wait for ack or expiry in WAIT_ACK.
    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        target_d   = target_q;
        timer_d    = timer_q;
        timeout_d  = timeout_q;
        drop_d     = drop_q;
        pend_clr_s = 6'b000000;
        capt_clr_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sel_valid_s) begin
                    pend_clr_s = sel_mask_s;
                    if (sel_appl_s) begin
                        code_d   = sel_code_s;
                        target_d = sel_target_s;
                        timer_d  = TIMER_ZERO;
                        state_d  = ST_WAIT_ACK;
                    end else begin
                        drop_d = (drop_q == 8'hFF) ? drop_q : drop_q + 8'd1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_ACK: begin
                if (bus.mode_i == target_q) begin
                    code_d     = CODE_NONE;
                    state_d    = ST_IDLE;
                    capt_clr_s = (code_q == CODE_RESTART);
                end else if (timer_q == TIMER_LAST) begin
                    code_d    = CODE_NONE;
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    timer_d = timer_q + TIMER_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                code_d  = CODE_NONE;
            end
        endcase
        // New pulses win over a same-cycle clear so a re-pulse is never lost.
        pend_d = (pend_q & ~pend_clr_s) | evt_s;
        busy_d = (state_d == ST_WAIT_ACK);
    end

    // First-error capture: freeze PC and cause until a restart is acknowledged.
    always_comb begin
        capt_d  = capt_q;
        epc_d   = epc_q;
        cause_d = cause_q;
        if (capt_clr_s) begin
            capt_d = 1'b0;
        end else if (err_s && !capt_q) begin
            capt_d  = 1'b1;
            epc_d   = bus.pc_i;
            cause_d = {bus.misalign_i, bus.ill_instr_i};
        end else begin
            capt_d = capt_q;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            pend_q    <= 6'b000000;
            code_q    <= CODE_NONE;
            target_q  <= 4'd0;
            timer_q   <= TIMER_ZERO;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            drop_q    <= 8'd0;
            capt_q    <= 1'b0;
            epc_q     <= 32'd0;
            cause_q   <= 2'b00;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            code_q    <= code_d;
            target_q  <= target_d;
            timer_q   <= timer_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
            drop_q    <= drop_d;
            capt_q    <= capt_d;
            epc_q     <= epc_d;
            cause_q   <= cause_d;
        end
    end

    assign bus.exc_code_o = code_q;
    assign bus.busy_o     = busy_q;
    assign bus.epc_o      = epc_q;
    assign bus.cause_o    = cause_q;
    assign bus.timeout_o  = timeout_q;
    assign bus.drop_cnt_o = drop_q;

endmodule

// File: tb/tb_exc_encoder.sv
// Directed bench for exc_encoder: a rule-level event model checked every
// cycle, plus hand-computed checkpoints for each scenario.
module tb_exc_encoder;

    localparam int ACK_TO = 15;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    exc_encoder_if bus();

    exc_encoder #(.ACK_TIMEOUT(ACK_TO)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- behavioural model ----------------
    int          m_prio [6]   = '{2, 1, 5, 6, 4, 3};
    int          m_tgt  [1:6] = '{5, 2, 5, 4, 6, 5};
    bit          m_pend [1:6];
    int          m_code, m_target, m_wait, m_drop;
    bit          m_busy, m_timeout, m_capt;
    logic [31:0] m_epc;
    logic [1:0]  m_cause;

    function automatic bit m_appl(input int c, input int md);
        case (c)
            1, 2:    return md != 6;
            3:       return md == 4;
            4:       return (md != 2) && (md != 6);
            5:       return 1'b1;
            6:       return md == 6;
            default: return 1'b0;
        endcase
    endfunction

    initial begin : model
        int sel;
        bit ack_restart;
        forever begin
            @(posedge clk);
            if (rst) begin
                foreach (m_pend[k]) m_pend[k] = 1'b0;
                m_code = 0; m_target = 0; m_wait = 0; m_drop = 0;
                m_busy = 1'b0; m_timeout = 1'b0; m_capt = 1'b0;
                m_epc = 32'd0; m_cause = 2'b00;
            end else begin
                ack_restart = 1'b0;
                if (!m_busy) begin
                    sel = 0;
                    for (int i = 0; i < 6; i++)
                        if (sel == 0 && m_pend[m_prio[i]]) sel = m_prio[i];
                    if (sel != 0) begin
                        m_pend[sel] = 1'b0;
                        if (m_appl(sel, int'(bus.mode_i))) begin
                            m_code = sel; m_target = m_tgt[sel];
                            m_wait = 0; m_busy = 1'b1;
                        end else if (m_drop < 255) begin
                            m_drop++;
                        end
                    end
                end else begin
                    m_wait++;
                    if (int'(bus.mode_i) == m_target) begin
                        ack_restart = (m_code == 1);
                        m_code = 0; m_busy = 1'b0;
                    end else if (m_wait == ACK_TO) begin
                        m_code = 0; m_busy = 1'b0; m_timeout = 1'b1;
                    end
                end
                if (bus.restart_req_i) m_pend[1] = 1'b1;
                if (bus.ill_instr_i || bus.misalign_i) m_pend[2] = 1'b1;
                if (bus.resume_req_i) m_pend[3] = 1'b1;
                if (bus.pause_req_i) m_pend[4] = 1'b1;
                if (bus.uart_req_i) m_pend[5] = 1'b1;
                if (bus.uart_done_i) m_pend[6] = 1'b1;
                if (ack_restart) begin
                    m_capt = 1'b0;
                end else if ((bus.ill_instr_i || bus.misalign_i) && !m_capt) begin
                    m_capt = 1'b1; m_epc = bus.pc_i;
                    m_cause = {bus.misalign_i, bus.ill_instr_i};
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Every-cycle comparison against the model, just after the active edge.
    initial begin : compare
        @(posedge clk);
        forever begin
            @(posedge clk);
            #1;
            chk("m_code",    32'(bus.exc_code_o), 32'(m_code));
            chk("m_busy",    32'(bus.busy_o),     32'(m_busy));
            chk("m_epc",     bus.epc_o,           m_epc);
            chk("m_cause",   32'(bus.cause_o),    32'(m_cause));
            chk("m_timeout", 32'(bus.timeout_o),  32'(m_timeout));
            chk("m_drop",    32'(bus.drop_cnt_o), 32'(m_drop));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_pulses();
        bus.ill_instr_i = 1'b0; bus.misalign_i = 1'b0; bus.restart_req_i = 1'b0;
        bus.pause_req_i = 1'b0; bus.resume_req_i = 1'b0;
        bus.uart_req_i = 1'b0; bus.uart_done_i = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_pulses();
        tick(2);
        rst = 1'b0;
    endtask

    initial begin : stim
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        clear_pulses();
        bus.pc_i = 32'd0;
        bus.mode_i = 4'd5;
        tick(3);
        rst = 1'b0;
        chk("rst_code", 32'(bus.exc_code_o), 32'd0);
        chk("rst_busy", 32'(bus.busy_o), 32'd0);
        chk("rst_epc", bus.epc_o, 32'd0);
        chk("rst_drop", 32'(bus.drop_cnt_o), 32'd0);

        // pause in run mode, acknowledged a few cycles later
        bus.pause_req_i = 1'b1; tick(1); clear_pulses(); tick(1);
        chk("pause_code", 32'(bus.exc_code_o), 32'd4);
        chk("pause_busy", 32'(bus.busy_o), 32'd1);
        tick(2); bus.mode_i = 4'd4; tick(1);
        chk("pause_ack_code", 32'(bus.exc_code_o), 32'd0);
        chk("pause_ack_busy", 32'(bus.busy_o), 32'd0);
        bus.mode_i = 4'd5; tick(2);

        // resume while running is dropped
        bus.resume_req_i = 1'b1; tick(1); clear_pulses(); tick(1);
        chk("resume_drop", 32'(bus.drop_cnt_o), 32'd1);
        chk("resume_code", 32'(bus.exc_code_o), 32'd0);

        // pause + uart request together: uart first, pause then dropped in uart mode
        do_reset(); bus.mode_i = 4'd5;
        bus.pause_req_i = 1'b1; bus.uart_req_i = 1'b1; tick(1); clear_pulses(); tick(1);
        chk("uart_first", 32'(bus.exc_code_o), 32'd5);
        bus.mode_i = 4'd6; tick(1);
        chk("uart_ack", 32'(bus.exc_code_o), 32'd0);
        tick(1);
        chk("pause_dropped", 32'(bus.drop_cnt_o), 32'd1);
        bus.mode_i = 4'd5; tick(2);

        // double error capture, later error does not overwrite
        do_reset(); bus.mode_i = 4'd5; bus.pc_i = 32'h0000_0040;
        bus.ill_instr_i = 1'b1; bus.misalign_i = 1'b1; tick(1); clear_pulses();
        chk("epc_first", bus.epc_o, 32'h40);
        chk("cause_both", 32'(bus.cause_o), 32'd3);
        tick(1);
        chk("err_code", 32'(bus.exc_code_o), 32'd2);
        bus.mode_i = 4'd2; tick(1); bus.mode_i = 4'd5;
        bus.pc_i = 32'h0000_0080; bus.ill_instr_i = 1'b1; tick(1); clear_pulses(); tick(1);
        chk("err2_code", 32'(bus.exc_code_o), 32'd2);
        chk("epc_frozen", bus.epc_o, 32'h40);
        bus.mode_i = 4'd2; tick(1); bus.mode_i = 4'd5;
        // restart acknowledged immediately (mode already run), releases capture
        bus.restart_req_i = 1'b1; tick(1); clear_pulses(); tick(1);
        chk("restart_code", 32'(bus.exc_code_o), 32'd1);
        tick(1);
        chk("restart_one_cycle", 32'(bus.exc_code_o), 32'd0);
        bus.pc_i = 32'h0000_0100; bus.misalign_i = 1'b1; tick(1); clear_pulses();
        chk("epc_recapture", bus.epc_o, 32'h100);
        chk("cause_mis", 32'(bus.cause_o), 32'd2);
        tick(1); bus.mode_i = 4'd2; tick(1); bus.mode_i = 4'd5; tick(1);

        // error beats restart in the same cycle
        bus.restart_req_i = 1'b1; bus.ill_instr_i = 1'b1; tick(1); clear_pulses(); tick(1);
        chk("prio_err", 32'(bus.exc_code_o), 32'd2);
        bus.mode_i = 4'd2; tick(2);
        chk("prio_restart", 32'(bus.exc_code_o), 32'd1);
        bus.mode_i = 4'd5; tick(2);

        // ack timeout
        do_reset(); bus.mode_i = 4'd5;
        bus.pause_req_i = 1'b1; tick(1); clear_pulses(); tick(1);
        chk("to_code_start", 32'(bus.exc_code_o), 32'd4);
        tick(14);
        chk("to_code_last", 32'(bus.exc_code_o), 32'd4);
        chk("to_not_yet", 32'(bus.timeout_o), 32'd0);
        tick(1);
        chk("to_code_clear", 32'(bus.exc_code_o), 32'd0);
        chk("to_sticky", 32'(bus.timeout_o), 32'd1);

        // re-pulse during WAIT_ACK is serviced again
        do_reset(); bus.mode_i = 4'd5;
        bus.pause_req_i = 1'b1; tick(1); clear_pulses(); tick(1);
        bus.pause_req_i = 1'b1; tick(1); clear_pulses(); bus.mode_i = 4'd4; tick(1);
        chk("repulse_ack", 32'(bus.exc_code_o), 32'd0);
        tick(1);
        chk("repulse_again", 32'(bus.exc_code_o), 32'd4);
        tick(1); bus.mode_i = 4'd5; tick(1);

        // reset during WAIT_ACK, coincident pulse discarded
        do_reset(); bus.mode_i = 4'd5;
        bus.uart_req_i = 1'b1; tick(1); clear_pulses(); tick(1);
        chk("rw_code", 32'(bus.exc_code_o), 32'd5);
        rst = 1'b1; bus.restart_req_i = 1'b1; tick(1);
        chk("rw_code0", 32'(bus.exc_code_o), 32'd0);
        chk("rw_busy0", 32'(bus.busy_o), 32'd0);
        chk("rw_timeout0", 32'(bus.timeout_o), 32'd0);
        rst = 1'b0; clear_pulses(); tick(3);
        chk("rw_discard", 32'(bus.exc_code_o), 32'd0);

        // drop counter saturates, uart done outside uart mode also dropped
        bus.uart_done_i = 1'b1; tick(1); clear_pulses(); tick(1);
        chk("udone_drop", 32'(bus.drop_cnt_o), 32'd1);
        bus.resume_req_i = 1'b1; tick(300); clear_pulses(); tick(2);
        chk("drop_sat", 32'(bus.drop_cnt_o), 32'd255);

        tick(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/exc_encoder.md
EXC_ENCODER -- requirements
Module: exc_encoder

Interface
REQ-001 Parameter: ACK_TIMEOUT, default 15, max cycles in WAIT_ACK before abandoning a code.
REQ-002 clk_i  in  1  CPU clock; all logic on rising edge.
REQ-003 rst_i  in  1  reset; synchronous and active-high.
REQ-004 ill_instr_i  in  1  one-cycle pulse, illegal instruction.
REQ-005 misalign_i  in  1  one-cycle pulse, misaligned memory access.
REQ-006 restart_req_i  in  1  pulse, software restart.
REQ-007 pause_req_i  in  1  pulse, ecall halt.
REQ-008 resume_req_i  in  1  pulse, resume from pause.
REQ-009 uart_req_i  in  1  pulse, request UART program load.
REQ-010 uart_done_i  in  1  pulse, UART load finished.
REQ-011 pc_i  in  32  PC of the instruction raising the event.
REQ-012 mode_i  in  4  current mode from clock controller: 2 error, 4 pause, 5 run, 6 uart.
REQ-013 exc_code_o  out  4  code to clock controller, 0 = none.
REQ-014 busy_o  out  1  high while in WAIT_ACK.
REQ-015 epc_o  out  32  PC captured at first error.
REQ-016 cause_o  out  2  01 illegal, 10 misalign, 11 both same cycle.
REQ-017 timeout_o  out  1  sticky; a code was abandoned.
REQ-018 drop_cnt_o  out  8  count of events discarded as not applicable.

Function
REQ-019 Codes/targets: 1 restart->5, 2 error->2, 3 resume->5, 4 pause->4, 5 uart_req->6, 6 uart_done->5.
REQ-020 Each input pulse sets its pending bit at the next edge; ill_instr_i or misalign_i sets pending bit 2; pulses arriving while busy are retained.
REQ-021 Priority among pending bits: 2 > 1 > 5 > 6 > 4 > 3.
REQ-022 Applicability vs mode_i: 1 and 2 unless mode 6; 3 only in mode 4; 4 unless mode 2 or 6; 5 always; 6 only in mode 6.
REQ-023 FSM states IDLE, WAIT_ACK; reset state IDLE.
REQ-024 IDLE: highest-priority pending bit evaluated; if not applicable, clear it and increment drop_cnt_o (saturating at 255), stay IDLE, one bit per cycle.
REQ-025 IDLE with applicable bit: next edge sets exc_code_o = code, clears that pending bit, loads target, zeroes timer, enters WAIT_ACK.
REQ-026 Latency: pulse at edge n -> exc_code_o valid after edge n+2 when no other work pending.
REQ-027 WAIT_ACK: mode_i == target at an edge -> exc_code_o <= 0, enter IDLE.
REQ-028 WAIT_ACK: timer increments per cycle; at ACK_TIMEOUT without ack -> exc_code_o <= 0, timeout_o <= 1, enter IDLE.
REQ-029 mode_i already equal to target on entry: ack taken at first WAIT_ACK edge (one-cycle code).
REQ-030 Same event re-pulsed during WAIT_ACK re-sets its pending bit and is serviced again afterwards.
REQ-031 epc_o/cause_o load from pc_i only when an error pulse arrives and no error is captured; frozen until a code-1 ack clears capture state.
REQ-032 busy_o = (state == WAIT_ACK), registered.

Reset
REQ-033 rst_i high at an edge: state IDLE, pending 0, exc_code_o 0, busy_o 0, epc_o 0, cause_o 0, timeout_o 0, drop_cnt_o 0, timer 0.
REQ-034 Reset mid-WAIT_ACK abandons the code without setting timeout_o; event pulses coincident with reset are discarded.

Structure
REQ-035 Shared package exc_pkg holds code constants 0-6, mode constants 2/4/5/6, and default ACK_TIMEOUT.
REQ-036 One combinational sub-module exc_prio_sel: pending bits + mode_i -> selected code, target, applicable flag.

Verification
REQ-037 pause_req_i pulse, mode_i 5 -> code 4 two cycles later; mode_i to 4 after 3 cycles -> code 0 next edge, busy_o low.
REQ-038 ill_instr_i and misalign_i same cycle, pc_i 0x0000_0040 -> code 2, epc_o 0x40, cause_o 11; later error at 0x80 leaves epc_o 0x40.
REQ-039 resume_req_i while mode_i 5 -> no code, drop_cnt_o 1.
REQ-040 pause_req_i and uart_req_i same cycle, mode 5 -> code 5 first; after mode 6 ack, pause dropped (drop_cnt_o 1).
REQ-041 pause_req_i, mode_i held 5 -> code 4 for 15 cycles then 0, timeout_o 1.
REQ-042 rst_i asserted during WAIT_ACK -> all outputs 0 next edge, timeout_o 0.
